// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester with wait-state timeout
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [7:0]  pwdata,
    input  logic [7:0]  prdata,
    input  logic        pready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    logic        running;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_inc;
    logic        handshake;
    logic        done;
    logic        abort;

    assign wait_cnt_inc = wait_cnt + 16'd1;

    // Bus controls are pure state decodes so reset drops them immediately;
    // cmd_ready also waits for the first edge after reset release.
    assign cmd_ready = running && (state == ST_IDLE);
    assign psel      = (state != ST_IDLE);
    assign penable   = (state == ST_ACCESS);

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; ready completion wins over a timeout on the same edge
    always_comb begin
        state_next = state;
        handshake  = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && running) begin
                    handshake  = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end else if ((TIMEOUT_CNT != 16'd0) && (wait_cnt_inc == TIMEOUT_CNT)) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Marks the controller live from the first edge after reset release
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    // Command latch and wait-state counter
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr    <= 32'd0;
            pwrite   <= 1'b0;
            pwdata   <= 8'd0;
            wait_cnt <= 16'd0;
        end else if (handshake) begin
            paddr    <= cmd_addr;
            pwrite   <= cmd_write;
            pwdata   <= cmd_wdata;
            wait_cnt <= 16'd0;
        end else if ((state == ST_ACCESS) && !pready) begin
            wait_cnt <= wait_cnt_inc;
        end
    end

    // Response strobe plus held read data and error status
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done || abort;
            if (done) begin
                rsp_rdata <= pwrite ? 8'd0 : prdata;
                rsp_err   <= 1'b0;
            end else if (abort) begin
                rsp_rdata <= 8'd0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_valid_b;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        pready;
    logic [7:0]  prdata;

    logic        cmd_ready,   cmd_ready_b;
    logic        rsp_valid,   rsp_valid_b;
    logic [7:0]  rsp_rdata,   rsp_rdata_b;
    logic        rsp_err,     rsp_err_b;
    logic [31:0] paddr,       paddr_b;
    logic        psel,        psel_b;
    logic        penable,     penable_b;
    logic        pwrite,      pwrite_b;
    logic [7:0]  pwdata,      pwdata_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 pclk = ~pclk;

    apb_master #(.TIMEOUT(4)) u_dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    apb_master #(.TIMEOUT(2)) u_dut_b (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .paddr(paddr_b), .psel(psel_b), .penable(penable_b), .pwrite(pwrite_b),
        .pwdata(pwdata_b), .prdata(prdata), .pready(pready)
    );

    // Responder: pready after wait_n low ACCESS edges; optional byte memory
    int         wait_n    = 0;
    int         acc_waits = 0;
    logic [7:0] rd_val    = 8'h00;
    logic       mem_mode  = 1'b0;
    logic [7:0] mem [16]  = '{default: 8'h00};

    assign pready = (acc_waits >= wait_n);
    assign prdata = mem_mode ? mem[paddr[3:0]] : rd_val;

    always @(posedge pclk) begin
        if (((psel && penable) || (psel_b && penable_b)) && !pready)
            acc_waits <= acc_waits + 1;
        else if (!(psel || psel_b))
            acc_waits <= 0;
        if (psel && penable && pready && pwrite)
            mem[paddr[3:0]] <= pwdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    time hs_time;

    // Issue one command (called #1 after a rising edge) and follow it to rsp_valid
    task automatic run_cmd(input bit b, input bit wr, input logic [31:0] addr,
                           input logic [7:0] wd, input bit hold,
                           output int lat, output int pen_cnt,
                           output logic [7:0] rd, output logic err);
        bit got;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        chk("cmd_ready_idle", b ? cmd_ready_b : cmd_ready, 1);
        if (b) cmd_valid_b = 1'b1;
        else   cmd_valid   = 1'b1;
        @(posedge pclk);
        hs_time = $time;
        #1;
        if (hold) cmd_addr = 32'h99;
        else begin
            cmd_valid   = 1'b0;
            cmd_valid_b = 1'b0;
        end
        chk("setup_psel",    b ? psel_b    : psel,    1);
        chk("setup_penable", b ? penable_b : penable, 0);
        chk("setup_pwrite",  b ? pwrite_b  : pwrite,  wr);
        chk("setup_pwdata",  b ? pwdata_b  : pwdata,  wd);
        lat = 0; pen_cnt = 0; rd = 8'h00; err = 1'b0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge pclk);
            #1;
            lat++;
            if (b ? rsp_valid_b : rsp_valid) begin
                got = 1;
                rd  = b ? rsp_rdata_b : rsp_rdata;
                err = b ? rsp_err_b   : rsp_err;
                cmd_valid = 1'b0;
            end else begin
                if (b ? penable_b : penable) pen_cnt++;
                chk("paddr_stable",   b ? paddr_b : paddr, addr);
                chk("cmd_ready_busy", b ? cmd_ready_b : cmd_ready, 0);
            end
        end
        if (!got) chk("rsp_valid_seen", 0, 1);
    endtask

    int         lat, pen;
    logic [7:0] rd;
    logic       err;
    time        t_first;
    int         spurious;

    initial begin
        presetn = 1'b0; cmd_valid = 1'b0; cmd_valid_b = 1'b0;
        cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 8'd0;

        // Reset values
        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_psel",      psel,      0);
        chk("rst_penable",   penable,   0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err",   rsp_err,   0);
        chk("rst_paddr",     paddr,     0);
        chk("rst_pwrite",    pwrite,    0);
        chk("rst_pwdata",    pwdata,    0);
        #10 presetn = 1'b1;
        @(posedge pclk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write
        wait_n = 0;
        run_cmd(0, 1, 32'h5, 8'hA3, 0, lat, pen, rd, err);
        chk("zw_latency", lat, 2);
        chk("zw_access_cycles", pen, 1);
        chk("zw_rdata", rd, 8'h00);
        chk("zw_err", err, 0);

        // Wait-state read with cmd_valid held during the transfer
        wait_n = 3; rd_val = 8'h5C;
        run_cmd(0, 0, 32'h7, 8'h00, 1, lat, pen, rd, err);
        chk("ws_latency", lat, 5);
        chk("ws_access_cycles", pen, 4);
        chk("ws_rdata", rd, 8'h5C);
        chk("ws_err", err, 0);
        chk("ws_paddr_kept", paddr, 32'h7);

        // Timeout: responder never ready
        wait_n = 255;
        run_cmd(0, 0, 32'h9, 8'h00, 0, lat, pen, rd, err);
        chk("to_latency", lat, 5);
        chk("to_access_cycles", pen, 4);
        chk("to_err", err, 1);
        chk("to_rdata", rd, 8'h00);
        chk("to_psel", psel, 0);
        chk("to_penable", penable, 0);
        @(posedge pclk); #1;
        chk("to_rsp_one_cycle", rsp_valid, 0);

        // Normal read after timeout
        wait_n = 0; rd_val = 8'h77;
        run_cmd(0, 0, 32'hA, 8'h00, 0, lat, pen, rd, err);
        chk("after_to_err", err, 0);
        chk("after_to_rdata", rd, 8'h77);

        // Ready on the same edge the TIMEOUT=2 counter would expire
        wait_n = 1; rd_val = 8'h11;
        run_cmd(1, 0, 32'h20, 8'h00, 0, lat, pen, rd, err);
        chk("race_latency", lat, 3);
        chk("race_err", err, 0);
        chk("race_rdata", rd, 8'h11);

        // Back-to-back write then read against the memory responder
        wait_n = 0; mem_mode = 1'b1;
        run_cmd(0, 1, 32'h3, 8'h12, 0, lat, pen, rd, err);
        t_first = hs_time;
        chk("b2b_wr_err", err, 0);
        run_cmd(0, 0, 32'h3, 8'h00, 0, lat, pen, rd, err);
        chk("b2b_interval", 32'(hs_time - t_first), 30);
        chk("b2b_rdata", rd, 8'h12);
        chk("b2b_rd_latency", lat, 2);
        mem_mode = 1'b0;

        // Reset mid-ACCESS
        wait_n = 255;
        cmd_write = 1'b0; cmd_addr = 32'h4; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        chk("mid_penable_before", penable, 1);
        #2 presetn = 1'b0;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        @(posedge pclk); #2 presetn = 1'b1;
        @(posedge pclk); #1;
        chk("mid_post_cmd_ready", cmd_ready, 1);
        chk("mid_post_psel", psel, 0);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pclk); #1;
            if (rsp_valid) spurious++;
        end
        chk("mid_no_spurious_rsp", spurious, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
